sdram_stream_writer: RTL

Upstream feeder for one `sdram` controller channel. It takes a byte stream with a valid/ready handshake, for example ROM image data arriving from the MCU link. It packs consecutive bytes little-endian into 16-bit words and issues sequential write requests on the controller's toggle req/ack channel, starting at a programmed word address. It double-buffers, so byte intake overlaps the outstanding SDRAM write. It reports `busy` while a transfer is in progress and pulses `done` when the transfer completes.

---
 rtl/sdram_stream_writer_if.sv | 24 ++
 rtl/sdram_stream_writer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sdram_stream_writer_if.sv
// Byte-stream intake and toggle req/ack write channel of the SDRAM stream writer.
// The writer uses the master modport; the stream source and SDRAM controller use the slave modport.
interface sdram_stream_writer_if #(
    parameter int ADDR_BITS = 24
);
    logic                 s_valid;
    logic                 s_ready;
    logic [7:0]           s_data;
    logic                 mem_req;
    logic                 mem_ack;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_address;
    logic [15:0]          mem_data_write;

    modport master (
        input  s_valid, s_data, mem_ack,
        output s_ready, mem_req, mem_we, mem_address, mem_data_write
    );

    modport slave (
        output s_valid, s_data, mem_ack,
        input  s_ready, mem_req, mem_we, mem_address, mem_data_write
    );
endinterface

// File: rtl/sdram_stream_writer.sv
// Packs a byte stream little-endian into 16-bit words and writes them to consecutive SDRAM
// word addresses over a toggle req/ack channel, with a pack word and a hold word in flight.
module sdram_stream_writer #(
    parameter int ADDR_BITS = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   start_addr,
    input  logic [ADDR_BITS:0]     byte_count,
    sdram_stream_writer_if.master  bus,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   REM_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_BITS-1:0] addr;        // address of the word currently in the hold register
    logic [ADDR_BITS:0]   remaining;
    logic [15:0]          pack_data;
    logic                 pack_idx;
    logic                 pack_full;
    logic [15:0]          hold_data;
    logic                 hold_valid;
    logic                 issued;
    logic                 req_q;
    logic                 we_q;
    logic [ADDR_BITS-1:0] address_q;
    logic [15:0]          wdata_q;

    logic                 pending;
    logic                 write_done;
    logic                 hold_free;
    logic                 load_hold;
    logic                 issue_held;
    logic                 issue_next;
    logic                 accept;
    logic                 last_byte;
    logic [ADDR_BITS-1:0] addr_inc;

    assign pending    = req_q != bus.mem_ack;
    assign write_done = hold_valid && issued && !pending;
    assign hold_free  = !hold_valid || write_done;
    assign load_hold  = pack_full && hold_free;
    assign issue_held = hold_valid && !issued;
    // A word that completes while the previous write is acknowledged goes out on the same edge.
    assign issue_next = load_hold && write_done;
    assign last_byte  = remaining == REM_ONE;
    assign addr_inc   = addr + ADDR_ONE;

    assign bus.s_ready        = (state == ST_RUN) && !pack_full && (remaining != '0);
    assign accept             = bus.s_valid && bus.s_ready;
    assign bus.mem_req        = req_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_address    = address_q;
    assign bus.mem_data_write = wdata_q;

    assign busy = state == ST_RUN;
    assign done = state == ST_DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no branch leaves state_next unassigned and infers a latch.
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = (byte_count == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (remaining == '0 && !pack_full && hold_free) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr       <= '0;
            remaining  <= '0;
            pack_data  <= '0;
            pack_idx   <= 1'b0;
            pack_full  <= 1'b0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            issued     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every branch below reads pre-edge register values.
            if (state == ST_IDLE && start && byte_count != '0) begin
                addr      <= start_addr;
                remaining <= byte_count;
            end

            if (accept) begin
                remaining <= remaining - REM_ONE;
                if (!pack_idx) begin
                    pack_data <= {8'h00, bus.s_data};
                    if (last_byte) pack_full <= 1'b1;
                    else           pack_idx  <= 1'b1;
                end else begin
                    pack_data[15:8] <= bus.s_data;
                    pack_idx        <= 1'b0;
                    pack_full       <= 1'b1;
                end
            end

            if (load_hold) begin
                hold_data  <= pack_data;
                hold_valid <= 1'b1;
                pack_full  <= 1'b0;
            end

            if (write_done) begin
                addr <= addr_inc;
                if (!load_hold) begin
                    hold_valid <= 1'b0;
                    issued     <= 1'b0;
                    we_q       <= 1'b0;
                end
            end

            if (issue_held || issue_next) begin
                req_q     <= ~req_q;
                we_q      <= 1'b1;
                issued    <= 1'b1;
                address_q <= issue_held ? addr : addr_inc;
                wdata_q   <= issue_held ? hold_data : pack_data;
            end
        end
    end

endmodule
